cpu86_exec_wb_arbiter: RTL

//  Shares the single CPU86 register-file write port between NUM_REQ execution units (MOVU/ALU, STACKU, STR, XCHG).

---
 rtl/cpu86_exec_wb_arbiter_if.sv | 35 +++
 rtl/cpu86_exec_wb_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cpu86_exec_wb_arbiter_if.sv
// Writeback bus between the execution units, the arbiter and the register-file
// write port. The arbiter side uses the master modport because it masters the
// register-file write; the units/register-file side uses slave.
interface cpu86_exec_wb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*REG_W-1:0]  req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;

    logic                      wr_valid;
    logic                      wr_ready;
    logic [REG_W-1:0]          wr_reg;
    logic [DATA_W-1:0]         wr_data;
    logic [SRC_W-1:0]          wr_src;

    logic                      locked;
    logic                      err_reg;

    modport master (
        input  req_valid, req_reg, req_data, req_last, wr_ready,
        output req_ready, wr_valid, wr_reg, wr_data, wr_src, locked, err_reg
    );

    modport slave (
        output req_valid, req_reg, req_data, req_last, wr_ready,
        input  req_ready, wr_valid, wr_reg, wr_data, wr_src, locked, err_reg
    );
endinterface

// File: rtl/cpu86_exec_wb_arbiter.sv
// Register-file write-port arbiter for the CPU86 execution units.
// Round-robin grant between units, held for the whole of a multi-beat burst,
// followed by a single registered output stage towards the register file.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | no burst open; grant chosen round-robin from rr_ptr
//  ST_LOCKED | burst open; only lock_id may hand over beats until last=1
module cpu86_exec_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    cpu86_exec_wb_arbiter_if.master bus
);
    localparam int SRC_W = $clog2(NUM_REQ);
    // Register codes above FL (12) do not exist in the register file.
    localparam logic [REG_W-1:0] REG_MAX = REG_W'(12);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [SRC_W-1:0]    lock_id_q,  lock_id_d;
    logic [SRC_W-1:0]    rr_ptr_q,   rr_ptr_d;
    logic                wr_valid_q, wr_valid_d;
    logic [REG_W-1:0]    wr_reg_q,   wr_reg_d;
    logic [DATA_W-1:0]   wr_data_q,  wr_data_d;
    logic [SRC_W-1:0]    wr_src_q,   wr_src_d;
    logic                err_reg_q,  err_reg_d;

    logic                grant_vld;
    logic [SRC_W-1:0]    grant_id;
    logic [SRC_W:0]      scan_idx;
    logic                out_free;
    logic                accept;
    logic [REG_W-1:0]    beat_reg;
    logic [DATA_W-1:0]   beat_data;
    logic                beat_last;
    logic                beat_illegal;
    logic [SRC_W-1:0]    next_ptr;
    logic [NUM_REQ-1:0]  ready_vec;

    // Grant selection: lock owner while a burst is open, otherwise the first
    // valid unit found scanning upward from rr_ptr with wrap-around.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        if (state_q == ST_LOCKED) begin
            grant_id  = lock_id_q;
            grant_vld = bus.req_valid[lock_id_q];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
                if (scan_idx >= (SRC_W+1)'(NUM_REQ)) begin
                    scan_idx = scan_idx - (SRC_W+1)'(NUM_REQ);
                end
                if (!grant_vld && bus.req_valid[scan_idx[SRC_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_id  = scan_idx[SRC_W-1:0];
                end
            end
        end
    end

    // Handshake with the granted unit; the output slot is free when empty or
    // being drained this cycle, which gives 1 beat/clk with no bubble.
    always_comb begin
        out_free     = ~wr_valid_q | bus.wr_ready;
        accept       = out_free & grant_vld;
        beat_reg     = bus.req_reg[grant_id*REG_W +: REG_W];
        beat_data    = bus.req_data[grant_id*DATA_W +: DATA_W];
        beat_last    = bus.req_last[grant_id];
        beat_illegal = (beat_reg > REG_MAX);
        next_ptr     = (grant_id == SRC_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        ready_vec    = '0;
        if (accept) begin
            ready_vec[grant_id] = 1'b1;
        end
    end

    // Next-state: burst lock, round-robin pointer and the output stage.
    always_comb begin
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        rr_ptr_d   = rr_ptr_q;
        wr_valid_d = wr_valid_q;
        wr_reg_d   = wr_reg_q;
        wr_data_d  = wr_data_q;
        wr_src_d   = wr_src_q;
        err_reg_d  = accept & beat_illegal;

        // An illegal beat is consumed from the unit but never reaches the
        // register file; it still counts for lock/last bookkeeping below.
        if (accept) begin
            if (beat_illegal) begin
                wr_valid_d = 1'b0;
            end else begin
                wr_valid_d = 1'b1;
                wr_reg_d   = beat_reg;
                wr_data_d  = beat_data;
                wr_src_d   = grant_id;
            end
        end else if (bus.wr_ready) begin
            wr_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && !beat_last) begin
                    state_d   = ST_LOCKED;
                    lock_id_d = grant_id;
                end
            end
            ST_LOCKED: begin
                if (accept && beat_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pointer moves only when a writeback completes, so a burst never
        // shifts the fairness order mid-way.
        if (accept && beat_last) begin
            rr_ptr_d = next_ptr;
        end
    end

    // State and output registers; reset drops any open burst and pending beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            lock_id_q  <= '0;
            rr_ptr_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
            wr_src_q   <= '0;
            err_reg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_valid_q <= wr_valid_d;
            wr_reg_q   <= wr_reg_d;
            wr_data_q  <= wr_data_d;
            wr_src_q   <= wr_src_d;
            err_reg_q  <= err_reg_d;
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_reg    = wr_reg_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_src    = wr_src_q;
    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.err_reg   = err_reg_q;
endmodule
